// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, load/store port and byte-wide RAM port.
// The slave modport is the arbiter's view; master is the requesters/RAM side.
interface mem_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_done;
    logic [31:0] inst_data;
    logic        flush;

    logic        data_req;
    logic        data_we;
    logic        data_signed;
    logic [1:0]  data_len;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_done;

    logic        ram_rw;
    logic [31:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        io_buffer_full;

    modport slave (
        input  inst_req, inst_addr, flush,
        input  data_req, data_we, data_signed, data_len, data_addr, data_wdata,
        input  ram_rdata, io_buffer_full,
        output inst_done, inst_data, data_rdata, data_done,
        output ram_rw, ram_addr, ram_wdata
    );

    modport master (
        output inst_req, inst_addr, flush,
        output data_req, data_we, data_signed, data_len, data_addr, data_wdata,
        output ram_rdata, io_buffer_full,
        input  inst_done, inst_data, data_rdata, data_done,
        input  ram_rw, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetches and data loads/stores onto a byte-wide RAM port.
// Define MEM_ARB_RR_EN for round-robin arbitration; default gives data strict priority.
module mem_arbiter #(
    parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, INST_RD, DATA_RD, DATA_WR} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  last_q, last_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic        ram_rw_q, ram_rw_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [7:0]  ram_wdata_q, ram_wdata_d;
    logic        inst_done_q, inst_done_d;
    logic        data_done_q, data_done_d;
    logic [31:0] inst_data_q, inst_data_d;
    logic [31:0] data_rdata_q, data_rdata_d;
`ifdef MEM_ARB_RR_EN
    logic        data_last_q, data_last_d;
`endif

    logic [31:0] assembled;
    logic [31:0] io_off;
    logic [1:0]  cnt_nxt;
    logic        io_hit, done_any, data_ok, inst_ok, grant_data, grant_inst;

    function automatic logic [1:0] last_index(input logic [1:0] len);
        case (len)
            2'd0:    return 2'd0;
            2'd1:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] last,
                                           input logic sgn);
        case (last)
            2'd0:    return {{24{sgn & w[7]}}, w[7:0]};
            2'd1:    return {{16{sgn & w[15]}}, w[15:0]};
            default: return w;
        endcase
    endfunction

    // Unsigned offset test covers the whole 8-byte window without overflow at the top.
    assign io_off   = bus.data_addr - IO_BASE;
    assign io_hit   = (io_off < 32'd8);
    assign done_any = inst_done_q | data_done_q;
    assign data_ok  = bus.data_req & ~(bus.data_we & io_hit & bus.io_buffer_full) & ~done_any;
    assign inst_ok  = bus.inst_req & ~bus.flush & ~done_any;
`ifdef MEM_ARB_RR_EN
    assign grant_data = data_ok & (~inst_ok | ~data_last_q);
`else
    assign grant_data = data_ok;
`endif
    assign grant_inst = inst_ok & ~grant_data;
    assign cnt_nxt    = cnt_q + 2'd1;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        rbuf_d       = rbuf_q;
        ram_rw_d     = ram_rw_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        inst_done_d  = 1'b0;
        data_done_d  = 1'b0;
        inst_data_d  = inst_data_q;
        data_rdata_d = data_rdata_q;
`ifdef MEM_ARB_RR_EN
        data_last_d  = data_last_q;
`endif
        assembled = rbuf_q;
        assembled[{cnt_q, 3'b000} +: 8] = bus.ram_rdata;

        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    state_d    = bus.data_we ? DATA_WR : DATA_RD;
                    cnt_d      = 2'd0;
                    last_d     = last_index(bus.data_len);
                    ram_addr_d = bus.data_addr;
                    if (bus.data_we) begin
                        ram_rw_d    = 1'b1;
                        ram_wdata_d = bus.data_wdata[7:0];
                    end
`ifdef MEM_ARB_RR_EN
                    data_last_d = 1'b1;
`endif
                end else if (grant_inst) begin
                    state_d    = INST_RD;
                    cnt_d      = 2'd0;
                    last_d     = 2'd3;
                    ram_addr_d = bus.inst_addr;
`ifdef MEM_ARB_RR_EN
                    data_last_d = 1'b0;
`endif
                end
            end
            INST_RD: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    rbuf_d = assembled;
                    if (cnt_q == last_q) begin
                        state_d     = IDLE;
                        inst_done_d = 1'b1;
                        inst_data_d = assembled;
                    end else begin
                        cnt_d      = cnt_nxt;
                        ram_addr_d = ram_addr_q + 32'd1;
                    end
                end
            end
            DATA_RD: begin
                rbuf_d = assembled;
                if (cnt_q == last_q) begin
                    state_d      = IDLE;
                    data_done_d  = 1'b1;
                    data_rdata_d = extend(assembled, last_q, bus.data_signed);
                end else begin
                    cnt_d      = cnt_nxt;
                    ram_addr_d = ram_addr_q + 32'd1;
                end
            end
            DATA_WR: begin
                if (cnt_q == last_q) begin
                    state_d     = IDLE;
                    ram_rw_d    = 1'b0;
                    data_done_d = 1'b1;
                end else begin
                    cnt_d       = cnt_nxt;
                    ram_addr_d  = ram_addr_q + 32'd1;
                    ram_wdata_d = bus.data_wdata[{cnt_nxt, 3'b000} +: 8];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            last_q       <= 2'd0;
            rbuf_q       <= 32'd0;
            ram_rw_q     <= 1'b0;
            ram_addr_q   <= 32'd0;
            ram_wdata_q  <= 8'd0;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
            inst_data_q  <= 32'd0;
            data_rdata_q <= 32'd0;
`ifdef MEM_ARB_RR_EN
            data_last_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            rbuf_q       <= rbuf_d;
            ram_rw_q     <= ram_rw_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            inst_done_q  <= inst_done_d;
            data_done_q  <= data_done_d;
            inst_data_q  <= inst_data_d;
            data_rdata_q <= data_rdata_d;
`ifdef MEM_ARB_RR_EN
            data_last_q  <= data_last_d;
`endif
        end
    end

    assign bus.ram_rw     = ram_rw_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign bus.inst_done  = inst_done_q;
    assign bus.data_done  = data_done_q;
    assign bus.inst_data  = inst_data_q;
    assign bus.data_rdata = data_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single transactions plus
// hand-written arbitration, I/O back-pressure, flush and reset sequences.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if bus();

    mem_arbiter #(.IO_BASE(32'h0003_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Byte RAM model: read data follows the registered address within the cycle.
    logic [7:0] mem [0:4095];
    bit         mem_ready = 1'b0;
    assign bus.ram_rdata = mem[bus.ram_addr[11:0]];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
            mem[12'h100] <= 8'h13; mem[12'h101] <= 8'h05;
            mem[12'h102] <= 8'h10; mem[12'h103] <= 8'h00;
            mem[12'h200] <= 8'h80;
            mem[12'h210] <= 8'h34; mem[12'h211] <= 8'h82;
            mem[12'h220] <= 8'h78; mem[12'h221] <= 8'h56;
            mem[12'h222] <= 8'h34; mem[12'h223] <= 8'h12;
            mem[12'h230] <= 8'h7F;
            mem_ready <= 1'b1;
        end else if (bus.ram_rw) begin
            mem[bus.ram_addr[11:0]] <= bus.ram_wdata;
        end
    end

    typedef struct {
        bit          is_inst;
        bit          we;
        bit          sgn;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          exp_n;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.inst_req = 1'b0; bus.inst_addr = 32'd0; bus.flush = 1'b0;
        bus.data_req = 1'b0; bus.data_we = 1'b0; bus.data_signed = 1'b0;
        bus.data_len = 2'd0; bus.data_addr = 32'd0; bus.data_wdata = 32'd0;
        bus.io_buffer_full = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Drives one transaction and measures edges from the sampling edge to done.
    task automatic do_txn(input vec_t v, input int idx);
        logic [31:0] other_before, res;
        int          lat;
        bit          rw_bad, done;
        @(negedge clk);
        other_before = v.is_inst ? bus.data_rdata : bus.inst_data;
        if (v.is_inst) begin
            bus.inst_req = 1'b1; bus.inst_addr = v.addr;
        end else begin
            bus.data_req = 1'b1; bus.data_we = v.we; bus.data_signed = v.sgn;
            bus.data_len = v.len; bus.data_addr = v.addr; bus.data_wdata = v.wdata;
        end
        @(posedge clk); #1;
        lat = 0; done = 1'b0;
        rw_bad = (bus.ram_rw !== v.we);
        while (!done && lat < 16) begin
            @(posedge clk); #1;
            lat++;
            done = v.is_inst ? bus.inst_done : bus.data_done;
            if (!v.we && bus.ram_rw) rw_bad = 1'b1;
        end
        res = v.is_inst ? bus.inst_data : bus.data_rdata;
        bus.inst_req = 1'b0; bus.data_req = 1'b0;
        check($sformatf("v%0d latency", idx), lat, v.exp_n);
        check($sformatf("v%0d ram_rw", idx), {31'd0, rw_bad}, 32'd0);
        if (!v.we) check($sformatf("v%0d result", idx), res, v.exp);
        check($sformatf("v%0d other_hold", idx),
              v.is_inst ? bus.data_rdata : bus.inst_data, other_before);
        @(posedge clk); #1;
        check($sformatf("v%0d done_pulse", idx),
              {31'd0, v.is_inst ? bus.inst_done : bus.data_done}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int  lat;
        int  first;
        bit  got_i, got_d, bad;
        logic [31:0] i_res, d_res;
        int  exp_first;

        //                inst we   sgn  len   addr          wdata          exp            N
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h0000_0100, 32'h0,         32'h0010_0513, 4};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0000_0200, 32'h0,         32'hFFFF_FF80, 1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h0000_0200, 32'h0,         32'h0000_0080, 1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 2'd1, 32'h0000_0210, 32'h0,         32'hFFFF_8234, 2};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 2'd1, 32'h0000_0210, 32'h0,         32'h0000_8234, 2};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 2'd3, 32'h0000_0220, 32'h0,         32'h1234_5678, 4};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 2'd2, 32'h0000_0220, 32'h0,         32'h1234_5678, 4};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0000_0230, 32'h0,         32'h0000_007F, 1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 2'd3, 32'h0000_0240, 32'hCAFE_F00D, 32'h0,         4};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 2'd3, 32'h0000_0240, 32'h0,         32'hCAFE_F00D, 4};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_0241, 32'h1234_56A5, 32'h0,         1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 2'd3, 32'h0000_0240, 32'h0,         32'hCAFE_A50D, 4};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h0000_0240, 32'h0,         32'hCAFE_A50D, 4};

        clear_inputs();
        repeat (3) @(posedge clk);
        #2;
        check("rst inst_done", {31'd0, bus.inst_done}, 32'd0);
        check("rst data_done", {31'd0, bus.data_done}, 32'd0);
        check("rst ram_rw", {31'd0, bus.ram_rw}, 32'd0);
        check("rst ram_addr", bus.ram_addr, 32'd0);
        check("rst inst_data", bus.inst_data, 32'd0);
        check("rst data_rdata", bus.data_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        idle_cycles(1);

        for (int i = 0; i < 13; i++) do_txn(vecs[i], i);

        // Half store: byte-by-byte write timing relative to the sampling edge.
        bus.data_req = 1'b1; bus.data_we = 1'b1; bus.data_len = 2'd1;
        bus.data_addr = 32'h300; bus.data_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        check("hs E0 wr", {bus.ram_rw, 15'd0, bus.ram_addr[7:0], bus.ram_wdata},
              {1'b1, 15'd0, 8'h00, 8'hEF});
        check("hs E0 addr", bus.ram_addr, 32'h300);
        @(posedge clk); #1;
        check("hs E1 wr", {bus.ram_rw, 23'd0, bus.ram_wdata}, {1'b1, 23'd0, 8'hBE});
        check("hs E1 addr", bus.ram_addr, 32'h301);
        @(posedge clk); #1;
        check("hs E2 rw_done", {30'd0, bus.ram_rw, bus.data_done}, 32'd1);
        bus.data_req = 1'b0; bus.data_we = 1'b0;
        idle_cycles(2);
        check("hs mem", {16'd0, mem[12'h301], mem[12'h300]}, 32'h0000_BEEF);

        // Simultaneous fetch and signed byte load.
`ifdef MEM_ARB_RR_EN
        exp_first = 2;
`else
        exp_first = 1;
`endif
        bus.inst_req = 1'b1; bus.inst_addr = 32'h100;
        bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_signed = 1'b1;
        bus.data_len = 2'd0; bus.data_addr = 32'h200;
        @(posedge clk); #1;
        check("arb E0 addr", bus.ram_addr, (exp_first == 1) ? 32'h200 : 32'h100);
        first = 0; got_i = 1'b0; got_d = 1'b0; i_res = 32'd0; d_res = 32'd0;
        for (int k = 0; k < 20 && !(got_i && got_d); k++) begin
            @(posedge clk); #1;
            if (bus.data_done) begin
                got_d = 1'b1; d_res = bus.data_rdata; bus.data_req = 1'b0;
                if (first == 0) first = 1;
            end
            if (bus.inst_done) begin
                got_i = 1'b1; i_res = bus.inst_data; bus.inst_req = 1'b0;
                if (first == 0) first = 2;
            end
        end
        bus.inst_req = 1'b0; bus.data_req = 1'b0;
        check("arb first", first, exp_first);
        check("arb both", {30'd0, got_i, got_d}, 32'd3);
        check("arb inst_data", i_res, 32'h0010_0513);
        check("arb data_rdata", d_res, 32'hFFFF_FF80);
        idle_cycles(2);

        // I/O window store held off by a full buffer.
        bus.io_buffer_full = 1'b1;
        bus.data_req = 1'b1; bus.data_we = 1'b1; bus.data_len = 2'd0;
        bus.data_addr = 32'h0003_0000; bus.data_wdata = 32'h0000_005A;
        bad = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.ram_rw || bus.data_done) bad = 1'b1;
        end
        check("io blocked", {31'd0, bad}, 32'd0);
        @(negedge clk);
        bus.io_buffer_full = 1'b0;
        @(posedge clk); #1;
        check("io grant", {bus.ram_rw, bus.ram_addr[30:0]}, {1'b1, 31'h0003_0000});
        @(posedge clk); #1;
        check("io done", {31'd0, bus.data_done}, 32'd1);
        bus.data_req = 1'b0; bus.data_we = 1'b0;
        idle_cycles(2);

        // Flush sampled at E3 of a fetch cancels it without inst_done.
        bus.inst_req = 1'b1; bus.inst_addr = 32'h220;
        repeat (3) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        check("flush E3 done", {31'd0, bus.inst_done}, 32'd0);
        bus.inst_req = 1'b0; bus.flush = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.inst_done) bad = 1'b1;
        end
        check("flush no done", {31'd0, bad}, 32'd0);
        check("flush inst_data", bus.inst_data, 32'h0010_0513);
        @(negedge clk);

        // Flush in IDLE defers the fetch grant by one edge.
        bus.inst_req = 1'b1; bus.inst_addr = 32'h100; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        lat = 0;
        while (!bus.inst_done && lat < 16) begin
            @(posedge clk); #1;
            lat++;
        end
        bus.inst_req = 1'b0;
        check("idle flush latency", lat, 5);
        idle_cycles(2);

        // Reset asserted mid-store aborts it immediately.
        bus.data_req = 1'b1; bus.data_we = 1'b1; bus.data_len = 2'd3;
        bus.data_addr = 32'h250; bus.data_wdata = 32'h1122_3344;
        @(posedge clk); @(posedge clk); #1;
        check("rst store active", {31'd0, bus.ram_rw}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rst store rw", {31'd0, bus.ram_rw}, 32'd0);
        check("rst store done", {31'd0, bus.data_done}, 32'd0);
        bus.data_req = 1'b0; bus.data_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        bad = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.data_done || bus.ram_rw) bad = 1'b1;
        end
        check("rst no done", {31'd0, bad}, 32'd0);
        check("rst mem", {16'd0, mem[12'h251], mem[12'h250]}, 32'h0000_0044);
        check("rst rdata cleared", bus.data_rdata, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter IO_BASE, default 32'h0003_0000, base of the 8-byte memory-mapped I/O window.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports inst_req  input  1  fetch request; inst_addr  input  32  fetch byte address.
REQ-005 SHALL have ports inst_done  output  1  fetch complete pulse; inst_data  output  32  fetched word, little-endian.
REQ-006 SHALL have port flush  input  1  cancel any pending or active fetch.
REQ-007 SHALL have ports data_req  input  1; data_we  input  1 (1=store); data_signed  input  1; data_len  input  2 (0=byte, 1=half, 3=word); data_addr  input  32.
REQ-008 SHALL have ports data_wdata  input  32  store data, low bytes first; data_rdata  output  32  load result; data_done  output  1  completion pulse.
REQ-009 SHALL have ports ram_rw  output  1 (1=write); ram_addr  output  32; ram_wdata  output  8; ram_rdata  input  8 (valid one cycle after its address).
REQ-010 SHALL have port io_buffer_full  input  1  I/O write sink cannot accept data.

Function
REQ-011 SHALL implement states IDLE, INST_RD, DATA_RD, DATA_WR; ram_rw, ram_addr, ram_wdata, inst_done, data_done, inst_data, data_rdata are registered.
REQ-012 SHALL sample requests only in IDLE; the sampling edge is E0; the granted requester holds req and operands stable until its done.
REQ-013 SHALL use byte count N = 4 for fetches, data_len+1 for data (data_len=2 treated as 3, N=4).
REQ-014 SHALL, for reads, drive ram_addr = addr+i with ram_rw=0 from edge Ei, capture ram_rdata as byte i at edge E(i+1).
REQ-015 SHALL, for writes, drive ram_addr = addr+i, ram_wdata = data_wdata byte i, ram_rw=1 from edge Ei; ram_rw=0 from edge EN.
REQ-016 SHALL assert the matching done for exactly one cycle from edge EN, update the result at EN, and return to IDLE at EN; total latency N edges.
REQ-017 SHALL sign-extend loads from bit 7 (len 0) or bit 15 (len 1) when data_signed=1, zero-extend otherwise; words unchanged.
REQ-018 SHALL hold inst_data/data_rdata between transactions; ram_rw=0 whenever not in DATA_WR.
REQ-019 SHALL not grant in the cycle a done is high; the requester drops req in that cycle.
REQ-020 SHALL not grant a store with data_addr in [IO_BASE, IO_BASE+7] while io_buffer_full=1; an eligible fetch MAY be granted instead.
REQ-021 SHALL, on flush in INST_RD, return to IDLE at the next edge without inst_done; flush in IDLE blocks fetch grant that edge; flush never affects data transactions.
REQ-022 SHALL, with both requests eligible in IDLE, arbitrate per REQ-026.

Reset
REQ-023 SHALL, while rst=0, force state IDLE and all outputs to 0 regardless of clk.
REQ-024 SHALL abort any transaction on reset without issuing done; the round-robin pointer resets to favour data.

Configuration
REQ-025 SHALL support macro MEM_ARB_RR_EN.
REQ-026 SHALL, without MEM_ARB_RR_EN, grant data over fetch always; with it, grant the requester not granted most recently (round-robin), pointer updated at each grant.

Verification
REQ-027 Word fetch inst_addr=0x100, RAM bytes 0x13,0x05,0x10,0x00 -> inst_done at E4, inst_data=0x00100513, ram_rw=0 throughout.
REQ-028 Signed byte load addr=0x200, byte 0x80 -> data_done at E1, data_rdata=0xFFFFFF80; unsigned -> 0x00000080.
REQ-029 Half store addr=0x300, wdata=0xDEADBEEF -> ram writes 0xEF@0x300 (E0), 0xBE@0x301 (E1), ram_rw=0 and data_done at E2.
REQ-030 Simultaneous fetch and load in IDLE -> data granted first; with MEM_ARB_RR_EN and data last granted, fetch granted first.
REQ-031 Store to 0x30000 with io_buffer_full=1 for 5 cycles -> no write, ram_rw=0; grant on first edge after io_buffer_full=0.
REQ-032 flush at E2 of fetch -> IDLE at E3, no inst_done; rst low at E1 of a store -> ram_rw=0 immediately, no data_done.
